// File: rtl/nvram_port_arbiter_if.sv
// nvram_port_arbiter_if: bundles the CPU, HPS and shared-RAM buses of the
// NVRAM port arbiter.
//   master : the surrounding system (CPU core, HPS bridge, RAM macro)
//   slave  : the arbiter itself
interface nvram_port_arbiter_if #(
  parameter int NV_AW = 10
);
  // CPU side
  logic             cpu_cs;
  logic             cpu_we;
  logic [15:0]      cpu_addr;
  logic [7:0]       cpu_din;
  logic [7:0]       cpu_dout;
  // HPS side (NVRAM load/save)
  logic             hps_wr;
  logic             hps_rd;
  logic [NV_AW-1:0] hps_addr;
  logic [7:0]       hps_din;
  logic [7:0]       hps_dout;
  logic             hps_wait;
  logic             hps_err;
  // Shared RAM port
  logic [15:0]      mem_addr;
  logic [7:0]       mem_din;
  logic             mem_we;
  logic [7:0]       mem_q;
  // Save-needed indicator
  logic             nv_dirty;

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_din,
    output hps_wr, hps_rd, hps_addr, hps_din,
    output mem_q,
    input  cpu_dout, hps_dout, hps_wait, hps_err,
    input  mem_addr, mem_din, mem_we, nv_dirty
  );

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_din,
    input  hps_wr, hps_rd, hps_addr, hps_din,
    input  mem_q,
    output cpu_dout, hps_dout, hps_wait, hps_err,
    output mem_addr, mem_din, mem_we, nv_dirty
  );
endinterface

// File: rtl/nvram_port_arbiter.sv
// nvram_port_arbiter: shares one single-port synchronous RAM between the CPU
// (absolute priority, never stalled) and the HPS NVRAM load/save path, which
// slips into cycles where the CPU is not accessing RAM.
// Optional build macro: NVRAM_DIRTY_TRACK_EN enables the nv_dirty tracker
// (CPU writes into the NVRAM window since the last full save); without it
// nv_dirty is tied low and no window comparator is built.
module nvram_port_arbiter #(
  parameter logic [15:0] NV_BASE = 16'hCC00,
  parameter int          NV_AW   = 10
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  nvram_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, H_RD, H_WR, H_CAP} state_t;
  typedef enum logic {OWN_CPU, OWN_HPS} owner_t;

  // Reset: asserts asynchronously, releases two clk_sys edges later
  logic [1:0]  rst_sync_reg;
  logic        rst_int_n;

  state_t      state_reg, state_next;
  logic [15:0] hps_addr_reg, hps_addr_next;
  logic [7:0]  hps_din_reg, hps_din_next;
  logic        hps_err_reg, hps_err_next;
  logic        hps_strobe;

  // Read-data routing tag: who issued the RAM read in the previous cycle
  owner_t      owner_reg;
  logic        rd_pend_reg;
  logic [7:0]  cpu_dout_reg;
  logic [7:0]  hps_dout_reg;

  // Two-flop synchroniser for the reset release
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_int_n  = rst_sync_reg[1];
  assign hps_strobe = bus.hps_wr | bus.hps_rd;

  // FSM state and captured HPS request registers
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg    <= IDLE;
      hps_addr_reg <= 16'h0000;
      hps_din_reg  <= 8'h00;
      hps_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hps_addr_reg <= hps_addr_next;
      hps_din_reg  <= hps_din_next;
      hps_err_reg  <= hps_err_next;
    end
  end

  // Next-state: accept strobes only in IDLE, wait out CPU cycles, flag overruns
  always_comb begin
    state_next    = state_reg;
    hps_addr_next = hps_addr_reg;
    hps_din_next  = hps_din_reg;
    hps_err_next  = hps_err_reg;
    case (state_reg)
      IDLE: begin
        if (hps_strobe) begin
          // Window address formed once at capture; carry out of bit 15 dropped
          hps_addr_next = NV_BASE + 16'(bus.hps_addr);
          hps_din_next  = bus.hps_din;
        end
        if (bus.hps_wr) begin
          state_next = H_WR;
          // Simultaneous read and write: write wins, request is malformed
          if (bus.hps_rd) hps_err_next = 1'b1;
        end else if (bus.hps_rd) begin
          state_next = H_RD;
        end
      end
      H_RD: begin
        if (hps_strobe) hps_err_next = 1'b1;
        if (!bus.cpu_cs) state_next = H_CAP;
      end
      H_WR: begin
        if (hps_strobe) hps_err_next = 1'b1;
        if (!bus.cpu_cs) state_next = IDLE;
      end
      H_CAP: begin
        if (hps_strobe) hps_err_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shared RAM port mux: CPU first, then a pending HPS access, else idle
  always_comb begin
    bus.mem_addr = bus.cpu_addr;
    bus.mem_din  = bus.cpu_din;
    bus.mem_we   = 1'b0;
    if (bus.cpu_cs) begin
      bus.mem_we = bus.cpu_we;
    end else if (state_reg == H_RD) begin
      bus.mem_addr = hps_addr_reg;
    end else if (state_reg == H_WR) begin
      bus.mem_addr = hps_addr_reg;
      bus.mem_din  = hps_din_reg;
      bus.mem_we   = 1'b1;
    end
  end

  // Owner tag: remembers which side's read is returning on mem_q next cycle
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      owner_reg   <= OWN_CPU;
      rd_pend_reg <= 1'b0;
    end else if (bus.cpu_cs) begin
      owner_reg   <= OWN_CPU;
      rd_pend_reg <= ~bus.cpu_we;
    end else if (state_reg == H_RD) begin
      owner_reg   <= OWN_HPS;
      rd_pend_reg <= 1'b1;
    end else begin
      rd_pend_reg <= 1'b0;
    end
  end

  // Read-data capture: steer mem_q into the register of the tagged owner
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cpu_dout_reg <= 8'h00;
      hps_dout_reg <= 8'h00;
    end else begin
      if (rd_pend_reg && owner_reg == OWN_CPU)
        cpu_dout_reg <= bus.mem_q;
      if (rd_pend_reg && owner_reg == OWN_HPS && state_reg == H_CAP)
        hps_dout_reg <= bus.mem_q;
    end
  end

  assign bus.cpu_dout = cpu_dout_reg;
  assign bus.hps_dout = hps_dout_reg;
  assign bus.hps_err  = hps_err_reg;
  // Wait rises in the strobe cycle itself so the HPS never double-issues
  assign bus.hps_wait = (state_reg != IDLE) | hps_strobe;

`ifdef NVRAM_DIRTY_TRACK_EN
  // Window bounds in 17 bits so a window ending at 0xFFFF still compares right
  localparam logic [16:0] WIN_LO  = {1'b0, NV_BASE};
  localparam logic [16:0] WIN_HI  = WIN_LO + 17'(1 << NV_AW);
  localparam logic [15:0] NV_LAST = NV_BASE + 16'((1 << NV_AW) - 1);

  logic nv_dirty_reg;
  logic win_wr;
  logic save_done;

  assign win_wr    = bus.cpu_cs & bus.cpu_we &
                     ({1'b0, bus.cpu_addr} >= WIN_LO) &
                     ({1'b0, bus.cpu_addr} <  WIN_HI);
  // The last byte of the window being read back marks a complete save
  assign save_done = (state_reg == H_CAP) && (hps_addr_reg == NV_LAST);

  // Dirty flag: a window write beats a same-cycle save completion
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n)     nv_dirty_reg <= 1'b0;
    else if (win_wr)    nv_dirty_reg <= 1'b1;
    else if (save_done) nv_dirty_reg <= 1'b0;
  end

  assign bus.nv_dirty = nv_dirty_reg;
`else
  assign bus.nv_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_port_arbiter.sv
// tb_nvram_port_arbiter: directed stimulus with a scoreboard. Stimulus pushes
// expected RAM writes, CPU read data and HPS completions into queues; a
// monitor pops and compares whenever the DUT presents the matching event.
module tb_nvram_port_arbiter;
  localparam int NV_AW = 10;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  nvram_port_arbiter_if #(.NV_AW(NV_AW)) bus ();

  nvram_port_arbiter #(.NV_BASE(16'hCC00), .NV_AW(NV_AW)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous single-port RAM, 1-cycle read latency
  logic [7:0] ram [0:65535];
  always @(posedge clk_sys) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_q <= ram[bus.mem_addr];
  end

  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [7:0] dout; logic [7:0] cycles; } hx_t;
  wr_t        wq[$];
  logic [7:0] cq[$];
  hx_t        hq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("  ok %s: %0h", nm, act);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen with no expectation queued", nm);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
    wq.push_back('{addr: a, data: d});
    tick();
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
    bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    cq.push_back(exp);
    tick();
    bus.cpu_cs = 1'b0;
  endtask

  task automatic hps_write(input logic [9:0] off, input logic [7:0] d, input logic [7:0] dout_hold);
    bus.hps_wr = 1'b1; bus.hps_addr = off; bus.hps_din = d;
    wq.push_back('{addr: 16'hCC00 + 16'(off), data: d});
    hq.push_back('{dout: dout_hold, cycles: 8'd2});
    tick();
    bus.hps_wr = 1'b0;
  endtask

  task automatic hps_read(input logic [9:0] off, input logic [7:0] exp);
    bus.hps_rd = 1'b1; bus.hps_addr = off;
    hq.push_back('{dout: exp, cycles: 8'd3});
    tick();
    bus.hps_rd = 1'b0;
  endtask

  // Monitor: compares each DUT output event against the head of its queue
  initial begin
    int   wcnt;
    logic wprev, p0, p1;
    wr_t        we;
    logic [7:0] ce;
    hx_t        he;
    wcnt = 0; wprev = 1'b0; p0 = 1'b0; p1 = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        wcnt = 0; wprev = 1'b0; p0 = 1'b0; p1 = 1'b0;
      end else begin
        if (bus.mem_we === 1'b1) begin
          if (wq.size() == 0) fail_evt("mem_write");
          else begin
            we = wq.pop_front();
            chk("mem_write", {8'h00, bus.mem_addr, bus.mem_din}, {8'h00, we.addr, we.data});
          end
        end
        if (p1) begin
          if (cq.size() == 0) fail_evt("cpu_dout");
          else begin
            ce = cq.pop_front();
            chk("cpu_dout", {24'h0, bus.cpu_dout}, {24'h0, ce});
          end
        end
        p1 = p0;
        p0 = bus.cpu_cs & ~bus.cpu_we;
        if (bus.hps_wait === 1'b1) wcnt++;
        else if (wprev) begin
          if (hq.size() == 0) fail_evt("hps_done");
          else begin
            he = hq.pop_front();
            chk("hps_dout", {24'h0, bus.hps_dout}, {24'h0, he.dout});
            chk("hps_wait_len", 32'(wcnt), {24'h0, he.cycles});
          end
          wcnt = 0;
        end
        wprev = bus.hps_wait;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_din = 8'h00;
    bus.hps_wr = 1'b0; bus.hps_rd = 1'b0; bus.hps_addr = '0; bus.hps_din = 8'h00;
    reset_n = 1'b0;
    repeat (3) tick();
    @(negedge clk_sys);
    chk("rst_cpu_dout", {24'h0, bus.cpu_dout}, 32'h00);
    chk("rst_hps_dout", {24'h0, bus.hps_dout}, 32'h00);
    chk("rst_hps_wait", {31'h0, bus.hps_wait}, 32'h0);
    chk("rst_hps_err",  {31'h0, bus.hps_err},  32'h0);
    chk("rst_nv_dirty", {31'h0, bus.nv_dirty}, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();

    // Preload through the CPU port
    cpu_write(16'h0100, 8'hA5);
    cpu_write(16'hCC07, 8'h42);
    tick();

    // HPS write, CPU idle: write lands in the cycle after the strobe
    hps_write(10'h005, 8'h3C, 8'h00);
    @(negedge clk_sys);
    chk("wr_mem_we",   {31'h0, bus.mem_we}, 32'h1);
    chk("wr_mem_addr", {16'h0, bus.mem_addr}, 32'hCC05);
    repeat (2) tick();

    // HPS read held off by four CPU cycles
    bus.hps_rd = 1'b1; bus.hps_addr = 10'h005;
    hq.push_back('{dout: 8'h3C, cycles: 8'd7});
    tick();
    bus.hps_rd = 1'b0;
    bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      cq.push_back(8'hA5);
      if (i == 0) begin
        @(negedge clk_sys);
        chk("stall_mem_addr", {16'h0, bus.mem_addr}, 32'h0100);
      end
      tick();
    end
    bus.cpu_cs = 1'b0;
    @(negedge clk_sys);
    chk("svc_mem_addr", {16'h0, bus.mem_addr}, 32'hCC05);
    repeat (4) tick();

    // CPU read immediately followed by HPS read service
    cpu_write(16'h0100, 8'h77);
    hps_write(10'h005, 8'h96, 8'h3C);
    repeat (2) tick();
    bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
    cq.push_back(8'h77);
    bus.hps_rd = 1'b1; bus.hps_addr = 10'h005;
    hq.push_back('{dout: 8'h96, cycles: 8'd3});
    tick();
    bus.cpu_cs = 1'b0; bus.hps_rd = 1'b0;
    repeat (3) tick();

    // Strobe while busy is ignored and flags an error
    @(negedge clk_sys);
    chk("err_before", {31'h0, bus.hps_err}, 32'h0);
    tick();
    hps_read(10'h005, 8'h96);
    bus.hps_rd = 1'b1; bus.hps_addr = 10'h006;
    tick();
    bus.hps_rd = 1'b0;
    tick();
    @(negedge clk_sys);
    chk("err_overrun", {31'h0, bus.hps_err}, 32'h1);
    repeat (2) tick();

    // Reset pulse while an HPS write is stalled: write must be dropped
    bus.hps_wr = 1'b1; bus.hps_addr = 10'h007; bus.hps_din = 8'hAA;
    tick();
    bus.hps_wr = 1'b0;
    cpu_write(16'h0200, 8'h11);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("rst2_mem_we",   {31'h0, bus.mem_we},   32'h0);
    chk("rst2_hps_wait", {31'h0, bus.hps_wait}, 32'h0);
    chk("rst2_hps_err",  {31'h0, bus.hps_err},  32'h0);
    chk("rst2_cpu_dout", {24'h0, bus.cpu_dout}, 32'h00);
    chk("rst2_hps_dout", {24'h0, bus.hps_dout}, 32'h00);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    cpu_read(16'hCC07, 8'h42);
    repeat (2) tick();

    // Simultaneous read and write strobes: write wins, error set
    bus.hps_wr = 1'b1; bus.hps_rd = 1'b1; bus.hps_addr = 10'h009; bus.hps_din = 8'h5B;
    wq.push_back('{addr: 16'hCC09, data: 8'h5B});
    hq.push_back('{dout: 8'h00, cycles: 8'd2});
    tick();
    bus.hps_wr = 1'b0; bus.hps_rd = 1'b0;
    @(negedge clk_sys);
    chk("rdwr_err", {31'h0, bus.hps_err}, 32'h1);
    repeat (2) tick();
    hps_read(10'h009, 8'h5B);
    repeat (3) tick();

`ifdef NVRAM_DIRTY_TRACK_EN
    @(negedge clk_sys);
    chk("dirty_start", {31'h0, bus.nv_dirty}, 32'h0);
    tick();
    cpu_write(16'hD000, 8'h01);
    @(negedge clk_sys);
    chk("dirty_above", {31'h0, bus.nv_dirty}, 32'h0);
    tick();
    cpu_write(16'hCBFF, 8'h02);
    @(negedge clk_sys);
    chk("dirty_below", {31'h0, bus.nv_dirty}, 32'h0);
    tick();
    cpu_write(16'hCFFF, 8'hE1);
    @(negedge clk_sys);
    chk("dirty_set", {31'h0, bus.nv_dirty}, 32'h1);
    tick();
    cpu_write(16'hD000, 8'h03);
    @(negedge clk_sys);
    chk("dirty_hold", {31'h0, bus.nv_dirty}, 32'h1);
    tick();
    // Last-byte read with a window write in the capture cycle stays dirty
    hps_read(10'h3FF, 8'hE1);
    tick();
    cpu_write(16'hCC10, 8'h44);
    @(negedge clk_sys);
    chk("dirty_race", {31'h0, bus.nv_dirty}, 32'h1);
    repeat (2) tick();
    // Last-byte read completes cleanly: dirty clears
    hps_read(10'h3FF, 8'hE1);
    repeat (2) tick();
    @(negedge clk_sys);
    chk("dirty_clear", {31'h0, bus.nv_dirty}, 32'h0);
    tick();
`else
    cpu_write(16'hCFFF, 8'hE1);
    @(negedge clk_sys);
    chk("dirty_tied", {31'h0, bus.nv_dirty}, 32'h0);
    tick();
`endif

    repeat (6) tick();
    if (wq.size() != 0) begin n_cmp++; n_bad++; $display("FAIL write_drain: %0d writes never seen, expected 0", wq.size()); end
    if (cq.size() != 0) begin n_cmp++; n_bad++; $display("FAIL cpu_drain: %0d reads never seen, expected 0", cq.size()); end
    if (hq.size() != 0) begin n_cmp++; n_bad++; $display("FAIL hps_drain: %0d completions never seen, expected 0", hq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
